spi_rx_fifo: RTL

- SPI slave receiver that runs entirely in the system clock domain. It oversamples sck/ss/rx through synchronisers and supports all four SPI modes and either bit order.
- Accepts back-to-back words while ss stays low and queues them in a first-word-fall-through FIFO with a valid/ready output.
- Successor to the sck-clocked receiver: sits between the SPI pins and the MCU-side command decoder.

---
 rtl/spi_rx_fifo_pkg.sv | 23 ++
 rtl/spi_rx_fifo_sync_fifo.sv | 51 +++++
 rtl/spi_rx_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_fifo_pkg.sv
// Shared SPI definitions: FSM states, mode codes, clog2 helper.
// Reused by the RX FIFO receiver and later TX/master blocks.
package spi_rx_fifo_pkg;

  typedef enum logic {
    SPI_RX_IDLE  = 1'b0,
    SPI_RX_SHIFT = 1'b1
  } spi_rx_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  function automatic int spi_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO, extra-MSB pointers.
// A push while full only lands if a pop frees a slot.
module sync_fifo
  import spi_rx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             prst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = spi_clog2(DEPTH);

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (rd_en)
        rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_rx_fifo.sv
// SPI slave receiver oversampled in clk, words queued in a FWFT FIFO.
// Define SPI_RX_FIFO_ERR_CNT_EN for saturating overrun/frame-error counters.
module spi_rx_fifo
  import spi_rx_fifo_pkg::*;
#(
  parameter int         DATA_LENGTH = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [1:0] MODE        = SPI_MODE0,
  parameter bit         MSB_FIRST   = 1'b1
) (
  input  logic                   clk,
  input  logic                   prst,
  input  logic                   sck,
  input  logic                   ss,
  input  logic                   rx,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_err
`ifdef SPI_RX_FIFO_ERR_CNT_EN
  ,
  output logic [7:0]             overrun_cnt,
  output logic [7:0]             frame_err_cnt,
  input  logic                   clr_cnt
`endif
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int   CW   = spi_clog2(DATA_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH);

  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] rx_q;
  logic       sck_rise;
  logic       sck_fall;
  logic       sample;
  logic       ss_s;
  logic       rx_s;

  spi_rx_state_e          state_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [DATA_LENGTH-1:0] sh_q;
  logic [DATA_LENGTH-1:0] sh_d;
  logic [DATA_LENGTH-1:0] sh_base;
  logic [CW-1:0]          cnt_base;
  logic [DATA_LENGTH-1:0] word_q;
  logic                   push_q;
  logic                   fe_q;
  logic                   busy_q;
  logic                   ovr_q;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  // Two-flop synchronisers; third sck flop for edge detect
  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      sck_q <= {3{CPOL}};
      ss_q  <= 2'b11;
      rx_q  <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ss_q  <= {ss_q[0], ss};
      rx_q  <= {rx_q[0], rx};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  // Rising edge samples when CPOL and CPHA agree
  assign sample   = (CPOL == CPHA) ? sck_rise : sck_fall;
  assign ss_s     = ss_q[1];
  assign rx_s     = rx_q[1];

  // Next shift/count value; a fresh frame starts from zero
  always_comb begin
    sh_base  = (state_q == SPI_RX_IDLE) ? '0 : sh_q;
    cnt_base = (state_q == SPI_RX_IDLE) ? '0 : cnt_q;
    cnt_d    = cnt_base + 1'b1;
    if (MSB_FIRST)
      sh_d = {sh_base[DATA_LENGTH-2:0], rx_s};
    else
      sh_d = {rx_s, sh_base[DATA_LENGTH-1:1]};
  end

  // Frame FSM with registered push, busy and frame-error pulse
  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      state_q <= SPI_RX_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      push_q  <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      fe_q   <= 1'b0;
      unique case (state_q)
        SPI_RX_IDLE: begin
          busy_q <= 1'b0;
          if (!ss_s) begin
            state_q <= SPI_RX_SHIFT;
            busy_q  <= 1'b1;
            if (sample) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_d;
            end else begin
              sh_q  <= '0;
              cnt_q <= '0;
            end
          end
        end
        SPI_RX_SHIFT: begin
          if (ss_s) begin
            state_q <= SPI_RX_IDLE;
            busy_q  <= 1'b0;
            fe_q    <= (cnt_q != '0);
            cnt_q   <= '0;
            sh_q    <= '0;
          end else if (sample) begin
            sh_q <= sh_d;
            if (cnt_d == LAST) begin
              push_q <= 1'b1;
              word_q <= sh_d;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: state_q <= SPI_RX_IDLE;
      endcase
    end
  end

  assign fifo_pop = data_ready & ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .prst  (prst),
    .push  (push_q),
    .din   (word_q),
    .pop   (fifo_pop),
    .dout  (data_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Dropped-word pulse: push into a full FIFO with no pop
  always_ff @(posedge clk or posedge prst) begin
    if (prst) ovr_q <= 1'b0;
    else      ovr_q <= push_q & fifo_full & ~fifo_pop;
  end

  assign data_valid = ~fifo_empty;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
  assign frame_err  = fe_q;

`ifdef SPI_RX_FIFO_ERR_CNT_EN
  logic [7:0] ovr_cnt_q;
  logic [7:0] fe_cnt_q;

  // Saturating error counters; clear beats increment
  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      ovr_cnt_q <= '0;
      fe_cnt_q  <= '0;
    end else if (clr_cnt) begin
      ovr_cnt_q <= '0;
      fe_cnt_q  <= '0;
    end else begin
      if (ovr_q && ovr_cnt_q != 8'hFF)
        ovr_cnt_q <= ovr_cnt_q + 1'b1;
      if (fe_q && fe_cnt_q != 8'hFF)
        fe_cnt_q <= fe_cnt_q + 1'b1;
    end
  end

  assign overrun_cnt   = ovr_cnt_q;
  assign frame_err_cnt = fe_cnt_q;
`endif

endmodule
